// File: rtl/mem_stage.sv
// Memory pipeline stage: M register, data-memory handshake with wait-state stall
// and bounded timeout, and the W register feeding writeback.
module mem_stage #(
  parameter int MAX_WAIT = 15,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic [3:0]        RdE,
  input  logic [DATA_W-1:0] ALUResultE,
  input  logic [DATA_W-1:0] WriteDataE,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              mem_err,
  output logic              PCSrcW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [3:0]        RdW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [DATA_W-1:0] ReadDataW
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               pcsrc_m_q, pcsrc_m_d;
  logic               regwrite_m_q, regwrite_m_d;
  logic               memtoreg_m_q, memtoreg_m_d;
  logic               memwrite_m_q, memwrite_m_d;
  logic [3:0]         rd_m_q, rd_m_d;
  logic [DATA_W-1:0]  alu_m_q, alu_m_d;
  logic [DATA_W-1:0]  wdata_m_q, wdata_m_d;

  logic               pcsrc_w_q, pcsrc_w_d;
  logic               regwrite_w_q, regwrite_w_d;
  logic               memtoreg_w_q, memtoreg_w_d;
  logic [3:0]         rd_w_q, rd_w_d;
  logic [DATA_W-1:0]  aluout_w_q, aluout_w_d;
  logic [DATA_W-1:0]  rdata_w_q, rdata_w_d;

  logic               memop_s;
  logic               req_s;
  logic               stall_s;

  always_comb begin
    memop_s = memtoreg_m_q | memwrite_m_q;
    req_s   = memop_s & (state_q != S_ABORT);
    stall_s = req_s & ~mem_ready;
  end

  // Ready is checked before the timeout so a completion in the last allowed cycle wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (stall_s) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
          state_d = S_ABORT;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  always_comb begin
    pcsrc_m_d    = pcsrc_m_q;
    regwrite_m_d = regwrite_m_q;
    memtoreg_m_d = memtoreg_m_q;
    memwrite_m_d = memwrite_m_q;
    rd_m_d       = rd_m_q;
    alu_m_d      = alu_m_q;
    wdata_m_d    = wdata_m_q;
    if (!stall_s) begin
      pcsrc_m_d    = PCSrcE;
      regwrite_m_d = RegWriteE;
      memtoreg_m_d = MemtoRegE;
      memwrite_m_d = MemWriteE;
      rd_m_d       = RdE;
      alu_m_d      = ALUResultE;
      wdata_m_d    = WriteDataE;
    end else begin
      pcsrc_m_d    = pcsrc_m_q;
    end
  end

  // Stalled or aborted ops reach W as bubbles: control cleared, data held.
  always_comb begin
    pcsrc_w_d    = 1'b0;
    regwrite_w_d = 1'b0;
    memtoreg_w_d = 1'b0;
    rd_w_d       = rd_w_q;
    aluout_w_d   = aluout_w_q;
    rdata_w_d    = rdata_w_q;
    if (!stall_s && (state_q != S_ABORT)) begin
      pcsrc_w_d    = pcsrc_m_q;
      regwrite_w_d = regwrite_m_q;
      memtoreg_w_d = memtoreg_m_q;
      rd_w_d       = rd_m_q;
      aluout_w_d   = alu_m_q;
      if (memtoreg_m_q && req_s && mem_ready) begin
        rdata_w_d = mem_rdata;
      end else begin
        rdata_w_d = rdata_w_q;
      end
    end else begin
      pcsrc_w_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      err_q        <= 1'b0;
      pcsrc_m_q    <= 1'b0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      memwrite_m_q <= 1'b0;
      rd_m_q       <= 4'd0;
      alu_m_q      <= {DATA_W{1'b0}};
      wdata_m_q    <= {DATA_W{1'b0}};
      pcsrc_w_q    <= 1'b0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
      rd_w_q       <= 4'd0;
      aluout_w_q   <= {DATA_W{1'b0}};
      rdata_w_q    <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      pcsrc_m_q    <= pcsrc_m_d;
      regwrite_m_q <= regwrite_m_d;
      memtoreg_m_q <= memtoreg_m_d;
      memwrite_m_q <= memwrite_m_d;
      rd_m_q       <= rd_m_d;
      alu_m_q      <= alu_m_d;
      wdata_m_q    <= wdata_m_d;
      pcsrc_w_q    <= pcsrc_w_d;
      regwrite_w_q <= regwrite_w_d;
      memtoreg_w_q <= memtoreg_w_d;
      rd_w_q       <= rd_w_d;
      aluout_w_q   <= aluout_w_d;
      rdata_w_q    <= rdata_w_d;
    end
  end

  always_comb begin
    mem_req   = req_s;
    mem_we    = memwrite_m_q;
    mem_addr  = alu_m_q;
    mem_wdata = wdata_m_q;
    stall     = stall_s;
    mem_err   = err_q;
    PCSrcW    = pcsrc_w_q;
    RegWriteW = regwrite_w_q;
    MemtoRegW = memtoreg_w_q;
    RdW       = rd_w_q;
    ALUOutW   = aluout_w_q;
    ReadDataW = rdata_w_q;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage that sits directly downstream of the execute stage.
- Latches execute-stage results into an internal M register and runs the data-memory access through a req/ready handshake. Presents results to writeback through a W register.
- Generates the pipeline stall for wait-states and aborts hung accesses with a bounded timeout.

Parameters:
- MAX_WAIT, 15: wait cycles tolerated with mem_req high and mem_ready low before the access is aborted (1..255).
- DATA_W, 32: datapath and address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE  input  1 each  control from execute stage
- RdE  input  4  destination register
- ALUResultE  input  DATA_W  memory address / ALU result
- WriteDataE  input  DATA_W  store data
- mem_req  output  1  access request to data memory
- mem_we  output  1  1 = store, 0 = load; valid while mem_req
- mem_addr  output  DATA_W  ALUResultM
- mem_wdata  output  DATA_W  WriteDataM
- mem_rdata  input  DATA_W  load data; sampled on the edge where mem_req & mem_ready
- mem_ready  input  1  access completes this cycle
- stall  output  1  freezes execute-stage register and all upstream stages
- mem_err  output  1  sticky timeout flag
- PCSrcW, RegWriteW, MemtoRegW  output  1 each  control to writeback
- RdW  output  4  destination register to writeback
- ALUOutW, ReadDataW  output  DATA_W  writeback data

Behaviour:
- Reset: all M and W registers clear to 0 (bubble). FSM = IDLE, wait counter = 0, mem_err = 0, mem_req = 0, stall = 0.
  - Reset has priority over every other event, including mid-access. mem_req drops in the cycle after the reset edge.
- M register loads the E inputs on each edge where stall = 0 and holds them while stall = 1.
- memop_M = MemtoRegM | MemWriteM.
- mem_req = memop_M & (state != ABORT).
- mem_we = MemWriteM.
- stall = mem_req & ~mem_ready.
  - A zero-wait access (ready in the first req cycle) therefore produces no stall.
- FSM:
  - IDLE: if mem_req & ~mem_ready, go to WAIT and set counter = 1. Otherwise stay.
  - WAIT:
    - If mem_ready: go to IDLE and set counter = 0.
    - Else if counter == MAX_WAIT: go to ABORT and set mem_err = 1.
    - Else increment counter.
    - mem_ready wins over timeout when both occur in the same cycle.
  - ABORT: lasts one cycle. mem_req = 0, stall = 0. The aborted op advances to W as a bubble (RegWriteW = 0, MemtoRegW = 0, PCSrcW = 0). Go to IDLE.
- W register:
  - On an edge with stall = 0 and state != ABORT: loads PCSrcM, RegWriteM, MemtoRegM, RdM and ALUOutW = ALUResultM.
    - ReadDataW = mem_rdata if the op is a load completing this edge. Otherwise ReadDataW holds its previous value.
  - On an edge with stall = 1: W loads a bubble (all control 0, data held). This prevents repeated writeback.
- Latency: a non-memory op appears at W two edges after it is presented at E. A load/store takes 2 + (number of wait cycles) edges.
- mem_ready while mem_req = 0 is ignored. Store data is not returned to W.
- A store with RegWriteM = 1 passes RegWriteW through unchanged; that is the decoder's responsibility.
- mem_err stays 1 until reset. Later accesses proceed normally.
- Counter width is ceil(log2(MAX_WAIT + 1)) bits and never wraps.

Test Plan:
- Reset, then an ALU op (RegWriteE = 1, RdE = 3, ALUResultE = 0x0000_0010) -> two edges later RegWriteW = 1, RdW = 3, ALUOutW = 0x10. mem_req stays 0 and stall stays 0.
- Load at 0x100 with mem_ready = 1 in the first req cycle and mem_rdata = 0xDEAD_BEEF -> stall never asserts. Next edge ReadDataW = 0xDEADBEEF, MemtoRegW = 1.
- Store at 0x200 (WriteDataE = 0x1234) with ready after 3 wait cycles -> mem_we = 1 and mem_wdata = 0x1234 for 4 cycles. stall is high for 3 cycles and W receives 3 bubbles. The store reaches W on the 4th edge. The following ALU op is held in E and then flows through.
- Load with mem_ready held low and MAX_WAIT = 15 -> stall is high for 16 cycles, then an ABORT cycle with mem_req = 0. mem_err = 1 and RegWriteW = 0 for the aborted op. The next load completes normally with mem_err still 1.
- mem_ready rises in exactly the cycle counter == MAX_WAIT -> the load completes with the correct ReadDataW and mem_err stays 0.
- reset asserted during WAIT (counter = 5) -> next cycle mem_req = 0, stall = 0, all W outputs = 0. A pending mem_ready is ignored.
